// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: sequences 32-bit MEM-stage loads/stores as two half-word accesses on a 16-bit async SRAM.
// The pipeline freezes on ~ready; every SRAM pin is driven from a register.
module mem_sram_ctrl #(
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_wr;
    logic [ADDR_W-2:0] widx;
    logic [31:0]       wbuf;
    logic [31:0]       off;
    logic              req;
    logic              last;
    logic              unused_off;

    assign off        = addr - BASE_ADDR;
    assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};
    assign req        = wr_en | rd_en;
    assign last       = cnt == CW'(WAIT_CYCLES - 1);
    assign ready      = (state == IDLE && !req) || state == DONE;

    // Pins change on the same edge as the state so they are valid for the whole LO/HI window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            widx       <= '0;
            wbuf       <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_wr      <= wr_en;
                    widx       <= off[ADDR_W:2];
                    wbuf       <= wdata;
                    cnt        <= '0;
                    state      <= LO;
                    sram_addr  <= {off[ADDR_W:2], 1'b0};
                    sram_dq_o  <= wdata[15:0];
                    sram_dq_oe <= wr_en;
                    sram_we_n  <= !wr_en;
                    sram_oe_n  <= wr_en;
                end
                LO: if (last) begin
                    if (!op_wr) rdata[15:0] <= sram_dq_i;
                    cnt       <= '0;
                    state     <= HI;
                    sram_addr <= {widx, 1'b1};
                    sram_dq_o <= wbuf[31:16];
                end else begin
                    cnt <= cnt + CW'(1);
                end
                HI: if (last) begin
                    if (!op_wr) rdata[31:16] <= sram_dq_i;
                    cnt        <= '0;
                    state      <= DONE;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: checks mem_sram_ctrl against a word-level memory model and an SRAM behavioural model.
module tb_mem_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    logic [15:0] mem [0:4095];
    logic [31:0] ref_w [0:255];
    logic [31:0] ref_rdata = '0;
    int ntests = 0;
    int nfail = 0;

    mem_sram_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[11:0]] <= sram_dq_o;
    assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_addr[11:0]];

    // Called at posedge+1; returns at posedge+1 of the cycle after the access completes.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d, input string name);
        int lowc, wec, oec, idx;
        bit done;
        idx = int'(((a - 32'd1024) >> 2) & 32'd255);
        wr_en = wr; rd_en = rd; addr = a; wdata = d;
        if (wr) ref_w[idx] = d;
        else ref_rdata = ref_w[idx];
        lowc = 0; wec = 0; oec = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (!ready) lowc++;
            if (!sram_we_n) wec++;
            if (!sram_oe_n) oec++;
            if (ready) done = 1;
            else begin @(posedge clk); #1; end
        end
        ntests++;
        if (!done) begin nfail++; $display("FAIL %s timeout: ready never returned high", name); end
        ntests++;
        if (lowc !== 5) begin nfail++; $display("FAIL %s ready_low: got %0d cycles, want 5", name, lowc); end
        ntests++;
        if (wr ? (wec !== 4 || oec !== 0) : (oec !== 4 || wec !== 0)) begin
            nfail++; $display("FAIL %s strobes: we_n low %0d, oe_n low %0d, write=%0b", name, wec, oec, wr);
        end
        ntests++;
        if (rdata !== ref_rdata) begin nfail++; $display("FAIL %s rdata: got %h, want %h", name, rdata, ref_rdata); end
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        ntests++;
        if (got !== want) begin nfail++; $display("FAIL %s: got %h, want %h", name, got, want); end
    endtask

    task automatic test_reset;
        rst = 0; wr_en = 1; addr = 32'd1024; wdata = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        ntests++;
        if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
            nfail++; $display("FAIL reset_pins: got we_n/oe_n/dq_oe=%b, want 110", {sram_we_n, sram_oe_n, sram_dq_oe});
        end
        ntests++;
        if (rdata !== 32'h0) begin nfail++; $display("FAIL reset_rdata: got %h, want 0", rdata); end
        rst = 1; wr_en = 0;
        #1;
        ntests++;
        if (ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b, want 1", ready); end
        ref_rdata = 0;
    endtask

    task automatic test_store;
        access(1, 0, 32'd1024, 32'hDEADBEEF, "store");
        check16("store_lo", mem[0], 16'hBEEF);
        check16("store_hi", mem[1], 16'hDEAD);
    endtask

    task automatic test_load;
        access(0, 1, 32'd1024, 32'h0, "load");
    endtask

    task automatic test_back_to_back;
        access(1, 0, 32'd1028, 32'h12345678, "b2b_store");
        access(0, 1, 32'd1028, 32'h0, "b2b_load");
    endtask

    task automatic test_both;
        access(1, 1, 32'd1032, 32'hA5A55A5A, "both");
        check16("both_lo", mem[4], 16'h5A5A);
        check16("both_hi", mem[5], 16'hA5A5);
    endtask

    task automatic test_reset_mid;
        access(1, 0, 32'd1036, 32'hCAFEF00D, "mid_store");
        rd_en = 1; addr = 32'd1036;
        repeat (3) @(posedge clk);
        #1;
        ntests++;
        if (sram_oe_n !== 1'b0 || sram_addr !== 18'd7) begin
            nfail++; $display("FAIL mid_in_hi: got oe_n=%b addr=%0d, want 0/7", sram_oe_n, sram_addr);
        end
        rst = 0;
        @(posedge clk); #1;
        ntests++;
        if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
            nfail++; $display("FAIL mid_pins: got %b, want 110", {sram_we_n, sram_oe_n, sram_dq_oe});
        end
        ref_rdata = 0;
        ntests++;
        if (rdata !== ref_rdata) begin nfail++; $display("FAIL mid_rdata: got %h, want %h", rdata, ref_rdata); end
        rst = 1; rd_en = 0;
        #1;
        ntests++;
        if (ready !== 1'b1) begin nfail++; $display("FAIL mid_ready: got %b, want 1", ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        for (int i = 16; i < 32; i++) access(1, 0, 32'd1024 + 32'(4 * i), $urandom, "rnd_fill");
        for (int i = 0; i < 30; i++) begin
            int w, op;
            w = $urandom_range(16, 31);
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, 32'd1024 + 32'(4 * w), $urandom, "rnd_op");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_w[i] = '0;
        test_reset;
        test_store;
        test_load;
        test_back_to_back;
        test_both;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
